// File: rtl/local_ni.sv
// Local-port network interface for the bufferless BLESS router.
// Injection side: core flits are time-stamped into a circular queue whose head
// drives the router's local input and is popped on any injection grant.
// Ejection side: every valid flit leaving the router is captured into a FIFO
// that drains to the core; the router is never back-pressured.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TIME_WIDTH
`define TIME_WIDTH 8
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TIME_POS
`define TIME_POS 22
`endif

module local_ni #(
  parameter int unsigned INJ_DEPTH = 4,
  parameter int unsigned EJ_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   core_inj_valid,
  input  logic [`DATA_WIDTH-1:0] core_inj_data,
  output logic                   core_inj_ready,
  output logic [`DATA_WIDTH-1:0] inj_flit,
  input  logic                   inj_grant,
  input  logic [`DATA_WIDTH-1:0] ej_flit,
  output logic                   core_ej_valid,
  output logic [`DATA_WIDTH-1:0] core_ej_data,
  input  logic                   core_ej_ready,
  output logic                   ej_overflow,
  output logic [15:0]            inj_wait_cnt
);

  localparam int unsigned DW  = `DATA_WIDTH;
  localparam int unsigned TW  = `TIME_WIDTH;
  localparam int unsigned IAW = $clog2(INJ_DEPTH);
  localparam int unsigned EAW = $clog2(EJ_DEPTH);
  localparam logic [IAW:0] INJ_FULL = (IAW+1)'(INJ_DEPTH);
  localparam logic [EAW:0] EJ_FULL  = (EAW+1)'(EJ_DEPTH);

  logic [TW-1:0]  time_q;
  logic [DW-1:0]  inj_mem_q [INJ_DEPTH];
  logic [IAW-1:0] inj_wr_q, inj_rd_q;
  logic [IAW:0]   inj_cnt_q, inj_cnt_d;
  logic [15:0]    wait_q, wait_d;
  logic [DW-1:0]  ej_mem_q [EJ_DEPTH];
  logic [EAW-1:0] ej_wr_q, ej_rd_q;
  logic [EAW:0]   ej_cnt_q, ej_cnt_d;
  logic           ovf_q;

  logic          inj_push, inj_pop, ej_cap, ej_pop, ej_write, ej_drop;
  logic [DW-1:0] inj_entry;

  // Handshake decode and injection entry formatting
  always_comb begin
    core_inj_ready = (inj_cnt_q != INJ_FULL);
    inj_push       = core_inj_valid && core_inj_ready;
    inj_pop        = inj_grant && (inj_cnt_q != '0);
    core_ej_valid  = (ej_cnt_q != '0);
    ej_pop         = core_ej_valid && core_ej_ready;
    ej_cap         = ej_flit[`VALID_POS];
    // A capture on full is still accepted when the head leaves the same cycle.
    ej_write       = ej_cap && ((ej_cnt_q != EJ_FULL) || ej_pop);
    ej_drop        = ej_cap && !ej_write;
    inj_entry                   = core_inj_data;
    inj_entry[`VALID_POS]       = 1'b1;
    inj_entry[`TIME_POS +: TW]  = time_q;
  end

  // Next-state for counts and the head wait counter
  always_comb begin
    inj_cnt_d = inj_cnt_q;
    case ({inj_push, inj_pop})
      2'b10:   inj_cnt_d = inj_cnt_q + (IAW+1)'(1);
      2'b01:   inj_cnt_d = inj_cnt_q - (IAW+1)'(1);
      default: inj_cnt_d = inj_cnt_q;
    endcase
    ej_cnt_d = ej_cnt_q;
    case ({ej_write, ej_pop})
      2'b10:   ej_cnt_d = ej_cnt_q + (EAW+1)'(1);
      2'b01:   ej_cnt_d = ej_cnt_q - (EAW+1)'(1);
      default: ej_cnt_d = ej_cnt_q;
    endcase
    if (inj_pop || (inj_cnt_q == '0))  wait_d = '0;
    else if (wait_q == '1)             wait_d = wait_q;
    else                               wait_d = wait_q + 16'd1;
  end

  // Control state: time base, pointers, counts, wait counter, overflow flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_q    <= '0;
      inj_wr_q  <= '0;
      inj_rd_q  <= '0;
      inj_cnt_q <= '0;
      wait_q    <= '0;
      ej_wr_q   <= '0;
      ej_rd_q   <= '0;
      ej_cnt_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      time_q    <= time_q + TW'(1);
      inj_cnt_q <= inj_cnt_d;
      ej_cnt_q  <= ej_cnt_d;
      wait_q    <= wait_d;
      if (inj_push) inj_wr_q <= inj_wr_q + IAW'(1);
      if (inj_pop)  inj_rd_q <= inj_rd_q + IAW'(1);
      if (ej_write) ej_wr_q  <= ej_wr_q + EAW'(1);
      if (ej_pop)   ej_rd_q  <= ej_rd_q + EAW'(1);
      if (ej_drop)  ovf_q    <= 1'b1;
    end
  end

  // Queue storage; contents are only observed through the count-qualified heads
  always_ff @(posedge clk) begin
    if (inj_push) inj_mem_q[inj_wr_q] <= inj_entry;
    if (ej_write) ej_mem_q[ej_wr_q]   <= ej_flit;
  end

  // Output decode from registers only
  always_comb begin
    inj_flit     = (inj_cnt_q != '0) ? inj_mem_q[inj_rd_q] : '0;
    core_ej_data = (ej_cnt_q != '0) ? ej_mem_q[ej_rd_q] : '0;
    ej_overflow  = ovf_q;
    inj_wait_cnt = wait_q;
  end

endmodule

// File: tb/tb_local_ni.sv
// Self-checking bench for local_ni: directed scenarios followed by random
// traffic, compared against a queue-based reference model.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TIME_WIDTH
`define TIME_WIDTH 8
`endif
`ifndef VALID_POS
`define VALID_POS 31
`endif
`ifndef TIME_POS
`define TIME_POS 22
`endif

module tb_local_ni;
  localparam int DW = `DATA_WIDTH;
  localparam int TW = `TIME_WIDTH;
  localparam int VP = `VALID_POS;
  localparam int TP = `TIME_POS;
  localparam int IDEP = 4;
  localparam int EDEP = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          core_inj_valid = 1'b0;
  logic [DW-1:0] core_inj_data = '0;
  logic          core_inj_ready;
  logic [DW-1:0] inj_flit;
  logic          inj_grant = 1'b0;
  logic [DW-1:0] ej_flit = '0;
  logic          core_ej_valid;
  logic [DW-1:0] core_ej_data;
  logic          core_ej_ready = 1'b0;
  logic          ej_overflow;
  logic [15:0]   inj_wait_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_inj[$];
  logic [DW-1:0] m_ej[$];
  int            m_time;
  int            m_wait;
  bit            m_ovf;

  local_ni #(.INJ_DEPTH(IDEP), .EJ_DEPTH(EDEP)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_inj_valid(core_inj_valid), .core_inj_data(core_inj_data),
    .core_inj_ready(core_inj_ready), .inj_flit(inj_flit),
    .inj_grant(inj_grant), .ej_flit(ej_flit),
    .core_ej_valid(core_ej_valid), .core_ej_data(core_ej_data),
    .core_ej_ready(core_ej_ready), .ej_overflow(ej_overflow),
    .inj_wait_cnt(inj_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] stamp(input logic [DW-1:0] d, input int t);
    logic [DW-1:0] r;
    logic [DW-1:0] tv;
    r  = d;
    r[VP] = 1'b1;
    tv = DW'(t);
    for (int b = 0; b < TW; b++) r[TP+b] = tv[b];
    return r;
  endfunction

  function automatic logic [DW-1:0] ejv(input int k);
    logic [DW-1:0] r;
    r = DW'(k);
    r[VP] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_inj.delete();
    m_ej.delete();
    m_time = 0;
    m_wait = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":inj_ready"}, DW'(core_inj_ready), DW'(m_inj.size() != IDEP));
    chk({ctx, ":inj_flit"}, inj_flit, (m_inj.size() != 0) ? m_inj[0] : '0);
    chk({ctx, ":wait"}, DW'(inj_wait_cnt), DW'(m_wait));
    chk({ctx, ":ej_valid"}, DW'(core_ej_valid), DW'(m_ej.size() != 0));
    chk({ctx, ":ej_data"}, core_ej_data, (m_ej.size() != 0) ? m_ej[0] : '0);
    chk({ctx, ":ovf"}, DW'(ej_overflow), DW'(m_ovf));
  endtask

  // Apply inputs for one cycle, advance the model, clock, then compare.
  task automatic cyc(input string ctx, input bit iv, input logic [DW-1:0] id, input bit g,
                     input logic [DW-1:0] ef, input bit er);
    bit rdy, push, pop, ejpop;
    core_inj_valid = iv;
    core_inj_data  = id;
    inj_grant      = g;
    ej_flit        = ef;
    core_ej_ready  = er;
    rdy   = (m_inj.size() != IDEP);
    push  = iv && rdy;
    pop   = g && (m_inj.size() != 0);
    ejpop = er && (m_ej.size() != 0);
    if (pop || m_inj.size() == 0) m_wait = 0;
    else if (m_wait < 65535) m_wait++;
    if (pop) void'(m_inj.pop_front());
    if (push) m_inj.push_back(stamp(id, m_time));
    if (ejpop) void'(m_ej.pop_front());
    if (ef[VP]) begin
      if (m_ej.size() < EDEP) m_ej.push_back(ef);
      else m_ovf = 1'b1;
    end
    m_time = (m_time + 1) % (1 << TW);
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  initial begin
    model_reset();
    #11;
    check_all("reset");
    reset_n = 1'b1;

    // Injection basic: idle 3 cycles so the push sees time 3
    for (int i = 0; i < 3; i++) cyc("idle", 0, '0, 0, '0, 0);
    cyc("pushA", 1, 32'h7FFF_FFFF, 0, '0, 0);
    chk("stampA_time", DW'(inj_flit[TP +: TW]), DW'(3));
    chk("stampA_valid", DW'(inj_flit[VP]), DW'(1));
    for (int i = 0; i < 5; i++) cyc("holdA", 0, '0, 0, '0, 0);
    chk("waitA5", DW'(inj_wait_cnt), DW'(5));
    cyc("grantA", 0, '0, 1, '0, 0);
    chk("afterA_flit", inj_flit, '0);

    // Injection full and ordering
    for (int k = 1; k <= 4; k++) cyc("fill", 1, DW'(k), 0, '0, 1);
    chk("full_ready", DW'(core_inj_ready), DW'(0));
    cyc("offer5", 1, DW'(5), 1, '0, 0);
    chk("after5_ready", DW'(core_inj_ready), DW'(1));
    for (int k = 0; k < 4; k++) cyc("drain_inj", 0, '0, 1, '0, 0);

    // Spurious grant on empty queue
    for (int k = 0; k < 2; k++) cyc("spurious", 0, '0, 1, '0, 0);
    chk("spurious_flit", inj_flit, '0);

    // Ejection overflow
    for (int k = 1; k <= 5; k++) cyc("ej_fill", 0, '0, 0, ejv(k), 0);
    chk("ovf_set", DW'(ej_overflow), DW'(1));
    for (int k = 0; k < 4; k++) cyc("ej_drain", 0, '0, 0, '0, 1);

    // Reset to clear the sticky flag, then full with simultaneous drain
    #3 reset_n = 1'b0;
    model_reset();
    #1 check_all("rst1");
    #3 reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) cyc("ej_fill2", 0, '0, 0, ejv(16 + k), 0);
    cyc("ej_full_drain", 0, '0, 0, ejv(32'h2E), 1);
    chk("no_ovf", DW'(ej_overflow), DW'(0));
    for (int k = 0; k < 5; k++) cyc("ej_drain2", 0, '0, 0, '0, 1);

    // Reset mid-traffic with 3 injection and 2 ejection entries queued
    for (int k = 1; k <= 3; k++)
      cyc("mid_fill", 1, DW'(k), 0, (k <= 2) ? ejv(40 + k) : '0, 0);
    #3 reset_n = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    #4;
    @(posedge clk);
    #2 reset_n = 1'b1;
    cyc("post_rst_push", 1, 32'h0000_0ABC, 0, '0, 0);
    chk("post_rst_stamp", DW'(inj_flit[TP +: TW]), DW'(0));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] d, e;
      d = $urandom;
      e = $urandom;
      e[VP] = ($urandom_range(0, 99) < 45);
      cyc("rand", $urandom_range(0, 99) < 60, d, $urandom_range(0, 99) < 40,
          e, $urandom_range(0, 99) < 50);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
